// File: rtl/uart_imem_loader.sv
// UART boot loader: receives 8N1 bytes, builds little-endian 32-bit words and
// writes them sequentially into instruction memory, then releases the core.
module uart_imem_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 32,
   parameter int MAX_WORDS    = 256
) (
   input  logic              clk_o,
   input  logic              reset,
   input  logic              rx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              load_done,
   output logic              frame_err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [15:0]      MAX_CNT  = 16'(MAX_WORDS);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {L_CNT0, L_CNT1, L_DATA, L_LAST, L_DONE} ld_state_t;

   logic rx_meta_q, rx_sync_q;

   rx_state_t        rstate_q, rstate_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             armed_q, armed_d;
   logic             byte_valid_q, byte_valid_d;
   logic [7:0]       byte_q, byte_d;
   logic             stop_err;

   ld_state_t         lstate_q, lstate_d;
   logic [15:0]       count_q, count_d;
   logic [15:0]       new_count;
   logic [15:0]       word_idx_q, word_idx_d;
   logic [1:0]        byte_pos_q, byte_pos_d;
   logic [23:0]       asm_q, asm_d;
   logic              imem_we_q, imem_we_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic              core_hold_q, core_hold_d;
   logic              load_done_q, load_done_d;
   logic              frame_err_q, frame_err_d;

   // Bit receiver. armed_q requires a high line in idle before a start is
   // accepted, so a stop-bit error on a held-low line cannot retrigger.
   always_comb begin
      rstate_d     = rstate_q;
      baud_d       = baud_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      armed_d      = armed_q;
      byte_valid_d = 1'b0;
      byte_d       = byte_q;
      stop_err     = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            if (!armed_q) begin
               armed_d = rx_sync_q;
            end else if (!rx_sync_q) begin
               rstate_d = R_START;
               baud_d   = '0;
            end
         end
         R_START: begin
            if (baud_q == HALF_CNT) begin
               baud_d = '0;
               if (!rx_sync_q) begin
                  rstate_d  = R_DATA;
                  bit_cnt_d = '0;
               end else begin
                  rstate_d = R_IDLE;
                  armed_d  = 1'b1;
               end
            end else begin
               baud_d = baud_q + CNT_ONE;
            end
         end
         R_DATA: begin
            if (baud_q == LAST_CNT) begin
               baud_d    = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) rstate_d = R_STOP;
            end else begin
               baud_d = baud_q + CNT_ONE;
            end
         end
         R_STOP: begin
            if (baud_q == LAST_CNT) begin
               baud_d   = '0;
               rstate_d = R_IDLE;
               armed_d  = rx_sync_q;
               if (rx_sync_q) begin
                  byte_valid_d = 1'b1;
                  byte_d       = shift_q;
               end else begin
                  stop_err = 1'b1;
               end
            end else begin
               baud_d = baud_q + CNT_ONE;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      lstate_d     = lstate_q;
      count_d      = count_q;
      new_count    = {byte_q, count_q[7:0]};
      word_idx_d   = word_idx_q;
      byte_pos_d   = byte_pos_q;
      asm_d        = asm_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      core_hold_d  = core_hold_q;
      load_done_d  = load_done_q;
      frame_err_d  = frame_err_q;
      if (stop_err && lstate_q != L_LAST && lstate_q != L_DONE) frame_err_d = 1'b1;
      case (lstate_q)
         L_CNT0: begin
            if (byte_valid_q) begin
               count_d  = {8'h00, byte_q};
               lstate_d = L_CNT1;
            end
         end
         L_CNT1: begin
            if (byte_valid_q) begin
               count_d = new_count;
               if (new_count == 16'd0 || new_count > MAX_CNT) begin
                  frame_err_d = 1'b1;
                  lstate_d    = L_CNT0;
               end else begin
                  lstate_d   = L_DATA;
                  word_idx_d = '0;
                  byte_pos_d = '0;
               end
            end
         end
         L_DATA: begin
            if (byte_valid_q) begin
               byte_pos_d = byte_pos_q + 2'd1;
               case (byte_pos_q)
                  2'd0: asm_d[7:0]   = byte_q;
                  2'd1: asm_d[15:8]  = byte_q;
                  2'd2: asm_d[23:16] = byte_q;
                  default: begin
                     imem_we_d    = 1'b1;
                     imem_wdata_d = {byte_q, asm_q};
                     imem_addr_d  = ADDR_W'({word_idx_q, 2'b00});
                     word_idx_d   = word_idx_q + 16'd1;
                     if (word_idx_q == count_q - 16'd1) lstate_d = L_LAST;
                  end
               endcase
            end
         end
         // Final write is on the bus this cycle; release the core next.
         L_LAST: begin
            lstate_d    = L_DONE;
            load_done_d = 1'b1;
            core_hold_d = 1'b0;
         end
         L_DONE: ;
         default: lstate_d = L_CNT0;
      endcase
   end

   always_ff @(posedge clk_o) begin
      if (!reset) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rstate_q     <= R_IDLE;
         baud_q       <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         armed_q      <= 1'b0;
         byte_valid_q <= 1'b0;
         byte_q       <= '0;
         lstate_q     <= L_CNT0;
         count_q      <= '0;
         word_idx_q   <= '0;
         byte_pos_q   <= '0;
         asm_q        <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_hold_q  <= 1'b1;
         load_done_q  <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_meta_q    <= rx;
         rx_sync_q    <= rx_meta_q;
         rstate_q     <= rstate_d;
         baud_q       <= baud_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         armed_q      <= armed_d;
         byte_valid_q <= byte_valid_d;
         byte_q       <= byte_d;
         lstate_q     <= lstate_d;
         count_q      <= count_d;
         word_idx_q   <= word_idx_d;
         byte_pos_q   <= byte_pos_d;
         asm_q        <= asm_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         core_hold_q  <= core_hold_d;
         load_done_q  <= load_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_hold  = core_hold_q;
   assign load_done  = load_done_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: table of load scenarios plus hand-written
// sequences for the idle glitch and the mid-word reset.
module tb_uart_imem_loader;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx = 1'b1;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_hold;
   logic        load_done;
   logic        frame_err;

   uart_imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(32), .MAX_WORDS(8)) dut (
      .clk_o(clk), .reset(reset), .rx(rx),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_hold(core_hold), .load_done(load_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Write monitor, sampled on the falling edge.
   int          cyc = 0;
   int          nwr = 0;
   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];
   int          last_we_cyc = 0;
   int          done_cyc = 0;
   logic        prev_done = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (imem_we) begin
         if (nwr < 64) begin
            wr_addr[nwr] = imem_addr;
            wr_data[nwr] = imem_wdata;
         end
         nwr = nwr + 1;
         last_we_cyc = cyc;
      end
      if (load_done && !prev_done) done_cyc = cyc;
      prev_done = load_done;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rx = 1'b1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   typedef struct {
      string       name;
      int          nb;
      logic [7:0]  b [14];
      logic [13:0] bad;
      int          nw;
      logic [31:0] ea [3];
      logic [31:0] ed [3];
      logic        edone;
      logic        eerr;
      logic        ehold;
   } vec_t;

   vec_t tbl [5];
   int   base;

   initial begin
      tbl[0].name = "two_words";
      tbl[0].nb = 12;
      tbl[0].b = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00,
                   8'h10, 8'h00, 8'hAA, 8'hBB, 8'h00, 8'h00};
      tbl[0].bad = '0;
      tbl[0].nw = 2;
      tbl[0].ea = '{32'h0, 32'h4, 32'h0};
      tbl[0].ed = '{32'h00000513, 32'h00100093, 32'h0};
      tbl[0].edone = 1'b1; tbl[0].eerr = 1'b0; tbl[0].ehold = 1'b0;

      tbl[1].name = "zero_count";
      tbl[1].nb = 8;
      tbl[1].b = '{8'h00, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[1].bad = '0;
      tbl[1].nw = 1;
      tbl[1].ea = '{32'h0, 32'h0, 32'h0};
      tbl[1].ed = '{32'hDEADBEEF, 32'h0, 32'h0};
      tbl[1].edone = 1'b1; tbl[1].eerr = 1'b1; tbl[1].ehold = 1'b0;

      tbl[2].name = "over_max";
      tbl[2].nb = 2;
      tbl[2].b = '{8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[2].bad = '0;
      tbl[2].nw = 0;
      tbl[2].ea = '{32'h0, 32'h0, 32'h0};
      tbl[2].ed = '{32'h0, 32'h0, 32'h0};
      tbl[2].edone = 1'b0; tbl[2].eerr = 1'b1; tbl[2].ehold = 1'b1;

      tbl[3].name = "bad_stop";
      tbl[3].nb = 7;
      tbl[3].b = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h99, 8'h33, 8'h44, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[3].bad = 14'h0010;
      tbl[3].nw = 1;
      tbl[3].ea = '{32'h0, 32'h0, 32'h0};
      tbl[3].ed = '{32'h44332211, 32'h0, 32'h0};
      tbl[3].edone = 1'b1; tbl[3].eerr = 1'b1; tbl[3].ehold = 1'b0;

      tbl[4].name = "three_words";
      tbl[4].nb = 14;
      tbl[4].b = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                   8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
      tbl[4].bad = '0;
      tbl[4].nw = 3;
      tbl[4].ea = '{32'h0, 32'h4, 32'h8};
      tbl[4].ed = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
      tbl[4].edone = 1'b1; tbl[4].eerr = 1'b0; tbl[4].ehold = 1'b0;

      // Reset values.
      rx = 1'b1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_hold", 32'(core_hold), 32'd1);
      chk("rst_we", 32'(imem_we), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_wdata", imem_wdata, 32'h0);
      chk("rst_done", 32'(load_done), 32'd0);
      chk("rst_err", 32'(frame_err), 32'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         do_reset();
         base = nwr;
         for (int j = 0; j < tbl[v].nb; j++) send_byte(tbl[v].b[j], !tbl[v].bad[j]);
         repeat (20) @(negedge clk);
         chk({tbl[v].name, "_nwr"}, 32'(nwr - base), 32'(tbl[v].nw));
         for (int k = 0; k < tbl[v].nw; k++) begin
            if (base + k < 64) begin
               chk({tbl[v].name, "_addr"}, wr_addr[base + k], tbl[v].ea[k]);
               chk({tbl[v].name, "_data"}, wr_data[base + k], tbl[v].ed[k]);
            end
         end
         chk({tbl[v].name, "_done"}, 32'(load_done), 32'(tbl[v].edone));
         chk({tbl[v].name, "_err"}, 32'(frame_err), 32'(tbl[v].eerr));
         chk({tbl[v].name, "_hold"}, 32'(core_hold), 32'(tbl[v].ehold));
         if (tbl[v].edone) chk({tbl[v].name, "_done_lat"}, 32'(done_cyc - last_we_cyc), 32'd1);
      end

      // One-cycle low glitch while idle must not produce a byte.
      do_reset();
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_err", 32'(frame_err), 32'd0);
      chk("glitch_hold", 32'(core_hold), 32'd1);
      base = nwr;
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h0D, 1'b1); send_byte(8'hF0, 1'b1);
      send_byte(8'hFE, 1'b1); send_byte(8'hCA, 1'b1);
      repeat (20) @(negedge clk);
      chk("glitch_nwr", 32'(nwr - base), 32'd1);
      if (base < 64) begin
         chk("glitch_addr", wr_addr[base], 32'h0);
         chk("glitch_data", wr_data[base], 32'hCAFEF00D);
      end
      chk("glitch_done", 32'(load_done), 32'd1);

      // Reset in the middle of the third word discards everything.
      do_reset();
      base = nwr;
      send_byte(8'h03, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'h04, 1'b1); send_byte(8'h03, 1'b1);
      send_byte(8'h02, 1'b1); send_byte(8'h01, 1'b1);
      send_byte(8'h08, 1'b1); send_byte(8'h07, 1'b1);
      send_byte(8'h06, 1'b1); send_byte(8'h05, 1'b1);
      send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
      repeat (5) @(negedge clk);
      chk("mid_nwr", 32'(nwr - base), 32'd2);
      chk("mid_addr_before", imem_addr, 32'h4);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_we", 32'(imem_we), 32'd0);
      chk("mid_rst_addr", imem_addr, 32'h0);
      chk("mid_rst_wdata", imem_wdata, 32'h0);
      chk("mid_rst_hold", 32'(core_hold), 32'd1);
      chk("mid_rst_done", 32'(load_done), 32'd0);
      chk("mid_rst_err", 32'(frame_err), 32'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      base = nwr;
      send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
      send_byte(8'hDE, 1'b1); send_byte(8'hC0, 1'b1);
      send_byte(8'hAD, 1'b1); send_byte(8'h0B, 1'b1);
      repeat (20) @(negedge clk);
      chk("fresh_nwr", 32'(nwr - base), 32'd1);
      if (base < 64) begin
         chk("fresh_addr", wr_addr[base], 32'h0);
         chk("fresh_data", wr_data[base], 32'h0BADC0DE);
      end
      chk("fresh_done", 32'(load_done), 32'd1);
      chk("fresh_hold", 32'(core_hold), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
